fetch_unit: RTL

Instruction-fetch stage of the pipelined ARM CPU, directly upstream of instruction decode. Holds the PC, issues requests to instruction memory over a req/ready handshake and computes branch targets from the offset fields produced by decode. Drives the IF/ID pipeline register: it holds that register on a decode stall and squashes it on a taken branch.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_unit_branch_target_gen.sv | 37 +++
 rtl/fetch_unit.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        RUN,
        HOLD,
        DRAIN
    } fetch_state_e;

    localparam int DEFAULT_ADDR_W = 64;  // PC / address width
    localparam int INSTR_W        = 32;  // instruction word width
    localparam int PC_INC         = 4;   // bytes per instruction

endpackage : fetch_pkg

// File: rtl/fetch_unit_branch_target_gen.sv
// Branch target generator: sign-extends the word offset selected by
// uncond_br, scales it to bytes and adds it to the IF/ID PC. A
// register-sourced branch overrides the PC-relative result.
module branch_target_gen
    import fetch_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic [ADDR_W-1:0] instr_pc,
    input  logic              uncond_br,
    input  logic              br_reg,
    input  logic [ADDR_W-1:0] br_reg_target,
    input  logic [25:0]       BrAddr26,
    input  logic [18:0]       CondAddr19,
    output logic [ADDR_W-1:0] target
);

    logic [ADDR_W-1:0] offset_ext;

    // Select and sign-extend the offset, then form the target address.
    always_comb begin
        // NOTE: every signal written here gets a value on every path, so no latch is inferred.
        offset_ext = '0;
        target     = '0;
        if (uncond_br) begin
            offset_ext = {{(ADDR_W-26){BrAddr26[25]}}, BrAddr26};
        end else begin
            offset_ext = {{(ADDR_W-19){CondAddr19[18]}}, CondAddr19};
        end
        if (br_reg) begin
            target = br_reg_target;
        end else begin
            target = instr_pc + (offset_ext << 2);
        end
    end

endmodule : branch_target_gen

// File: rtl/fetch_unit.sv
// Instruction-fetch stage. Owns the PC, requests words from instruction
// memory over a req/ready handshake and drives the IF/ID register.
// Optional feature macro: FETCH_PERF_CNT_EN adds fetch_bubbles and
// flush_count saturating performance counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              ADDR_W   = DEFAULT_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               br_taken,
    input  logic               uncond_br,
    input  logic               br_reg,
    input  logic [ADDR_W-1:0]  br_reg_target,
    input  logic [25:0]        BrAddr26,
    input  logic [18:0]        CondAddr19,
    output logic [INSTR_W-1:0] instruction,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic [ADDR_W-1:0]  pc_plus4,
    output logic               instr_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        fetch_bubbles,
    output logic [31:0]        flush_count
`endif
);

    fetch_state_e       state;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_seq;
    logic [ADDR_W-1:0]  redirect_pc;
    logic [ADDR_W-1:0]  br_target;
    logic [INSTR_W-1:0] skid_instr;
    logic [ADDR_W-1:0]  skid_pc;

    // The fetch address is the PC itself; in DRAIN the PC is frozen so the
    // outstanding request address stays stable until the memory answers.
    assign imem_addr = pc;
    assign pc_seq    = pc + ADDR_W'(PC_INC);
    assign pc_plus4  = instr_pc + ADDR_W'(PC_INC);

    branch_target_gen #(
        .ADDR_W (ADDR_W)
    ) u_branch_target_gen (
        .instr_pc      (instr_pc),
        .uncond_br     (uncond_br),
        .br_reg        (br_reg),
        .br_reg_target (br_reg_target),
        .BrAddr26      (BrAddr26),
        .CondAddr19    (CondAddr19),
        .target        (br_target)
    );

    // Fetch sequencer: PC, request, skid buffer and IF/ID register updates.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            pc          <= RESET_PC;
            redirect_pc <= '0;
            imem_req    <= 1'b1;
            instruction <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            skid_instr  <= '0;
            skid_pc     <= '0;
        end else begin
            // NOTE: non-blocking assignments make every branch read the pre-edge state.
            case (state)
                RUN: begin
                    if (br_taken) begin
                        instr_valid <= 1'b0;
                        if (imem_ready) begin
                            // Word fetched this cycle is the wrong path; drop it.
                            pc <= br_target;
                        end else begin
                            // Request still outstanding: let it finish first.
                            redirect_pc <= br_target;
                            state       <= DRAIN;
                        end
                    end else if (imem_ready) begin
                        pc <= pc_seq;
                        if (stall) begin
                            skid_instr <= imem_rdata;
                            skid_pc    <= pc;
                            imem_req   <= 1'b0;
                            state      <= HOLD;
                        end else begin
                            instruction <= imem_rdata;
                            instr_pc    <= pc;
                            instr_valid <= 1'b1;
                        end
                    end else if (!stall) begin
                        instr_valid <= 1'b0;
                    end
                end

                HOLD: begin
                    if (br_taken) begin
                        pc          <= br_target;
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        state       <= RUN;
                    end else if (!stall) begin
                        instruction <= skid_instr;
                        instr_pc    <= skid_pc;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b1;
                        state       <= RUN;
                    end
                end

                DRAIN: begin
                    if (imem_ready) begin
                        pc    <= redirect_pc;
                        state <= RUN;
                    end
                end

                default: begin
                    state    <= RUN;
                    imem_req <= 1'b1;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic br_accept;

    // A redirect only counts when the sequencer acts on it (not in DRAIN).
    assign br_accept = br_taken && (state != DRAIN);

    // Saturating bubble and flush counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_bubbles <= '0;
            flush_count   <= '0;
        end else begin
            if (!instr_valid && !stall && (fetch_bubbles != '1)) begin
                fetch_bubbles <= fetch_bubbles + 32'd1;
            end
            if (br_accept && (flush_count != '1)) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end
`endif

endmodule : fetch_unit
